// File: rtl/_req_encoder.sv
// Sequential priority encoder: accumulates requests into a pending register and
// presents the lowest-index pending bit as a binary code under a valid/ack handshake.
module _req_encoder #(
  parameter int unsigned n = 5,
  parameter int unsigned m = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [m-1:0] req,
  input  logic         flush,
  input  logic         ack,
  output logic [n-1:0] out,
  output logic         valid,
  output logic [m-1:0] pending,
  output logic         busy
);

  localparam logic [0:0] IDLE    = 1'b0;
  localparam logic [0:0] PRESENT = 1'b1;

  logic [0:0]   state;
  logic [0:0]   state_nxt;
  logic [n-1:0] out_nxt;
  logic [m-1:0] pending_nxt;
  logic [m-1:0] clr;
  logic [m-1:0] cand;
  logic [n-1:0] lsb_idx;

  // Bit being retired this cycle; candidates come from registered pending only.
  always_comb begin
    clr = '0;
    if (state == PRESENT && ack) begin
      clr = m'(1) << out;
    end
    cand = pending & ~clr;
  end

  // Lowest set bit of the candidate set wins.
  always_comb begin
    lsb_idx = '0;
    for (int i = int'(m) - 1; i >= 0; i--) begin
      if (cand[i]) begin
        lsb_idx = n'(i);
      end
    end
  end

  always_comb begin
    state_nxt   = state;
    out_nxt     = out;
    pending_nxt = cand | req;
    case (state)
      IDLE: begin
        if (|cand) begin
          out_nxt   = lsb_idx;
          state_nxt = PRESENT;
        end
      end
      PRESENT: begin
        if (ack) begin
          if (|cand) begin
            out_nxt = lsb_idx;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
    // Flush drops everything including same-cycle requests; out keeps its last code.
    if (flush) begin
      pending_nxt = '0;
      state_nxt   = IDLE;
      out_nxt     = out;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      out     <= '0;
      pending <= '0;
    end else begin
      state   <= state_nxt;
      out     <= out_nxt;
      pending <= pending_nxt;
    end
  end

  assign valid = (state == PRESENT);
  assign busy  = (|pending) | valid;

endmodule
